// File: rtl/execute_stage_pkg.sv
// Shared type definitions for the execute stage: instruction class, memory
// access type, ALU operation and FSM state encodings plus the branch-taken rule.
package execute_stage_pkg;

  typedef enum logic [2:0] {
    INSTR_NONE,
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_BRANCH,
    INSTR_JAL,
    INSTR_JALR
  } instr_type_t;

  typedef enum logic [2:0] {
    MEM_NONE,
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_BU,
    MEM_HU
  } mem_type_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_EQ,
    ALU_NE,
    ALU_GE,
    ALU_GEU,
    ALU_MUL
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_BUSY,
    ST_HOLD
  } ex_state_t;

  // Jumps always redirect; a branch redirects when its compare result is 1.
  function automatic logic is_taken(instr_type_t t, logic res0);
    return (t == INSTR_JAL) || (t == INSTR_JALR) || ((t == INSTR_BRANCH) && res0);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Upstream/downstream handshake bundle and redirect outputs of the execute stage.
interface execute_stage_if #(parameter int XLEN = 32);
  import execute_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  instr_type_t       in_instr_type;
  mem_type_t         in_mem_type;
  alu_op_t           in_op;
  logic [4:0]        in_dest;

  logic              out_valid;
  logic              out_ready;
  instr_type_t       out_instr_type;
  mem_type_t         out_mem_type;
  logic [4:0]        out_dest;
  logic [XLEN-1:0]   out_res;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;

  logic              jmp;
  logic [XLEN-1:0]   jmp_addr;
  logic              jmp_misaligned;

  modport slave (
    input  in_valid, in_pc, in_src1, in_src2, in_rs1_data, in_rs2_data, in_imm,
           in_instr_type, in_mem_type, in_op, in_dest, out_ready,
    output in_ready, out_valid, out_instr_type, out_mem_type, out_dest,
           out_res, out_rs2_data, out_imm, jmp, jmp_addr, jmp_misaligned
  );

  modport master (
    output in_valid, in_pc, in_src1, in_src2, in_rs1_data, in_rs2_data, in_imm,
           in_instr_type, in_mem_type, in_op, in_dest, out_ready,
    input  in_ready, out_valid, out_instr_type, out_mem_type, out_dest,
           out_res, out_rs2_data, out_imm, jmp, jmp_addr, jmp_misaligned
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles,
// done is high in the last iteration with product already showing the final sum.
module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign done     = (cnt == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (abort) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CW'(XLEN);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CW'(1);
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, iterative multiply, branch/jump resolution
// and a single-entry output holding register with valid/ready handshakes.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  execute_stage_if.slave   bus
);

  localparam int SW = $clog2(XLEN);

  ex_state_t       state, state_next;
  logic            jmp_q;
  instr_type_t     type_q;
  mem_type_t       mem_q;
  logic [4:0]      dest_q;
  logic [XLEN-1:0] res_q, rs2_q, imm_q, jaddr_q;

  logic            out_valid;
  logic            in_ready;
  logic            accept;
  logic            is_mul;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] jaddr_c;
  logic [SW-1:0]   shamt;

  assign out_valid = (state == ST_HOLD);
  assign in_ready  = (state != ST_MUL_BUSY) && !jmp_q && (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign is_mul    = MUL_EN && (bus.in_op == ALU_MUL);
  assign shamt     = bus.in_src2[SW-1:0];

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .abort   (rst || flush),
    .start   (accept && is_mul && !flush),
    .a       (bus.in_src1),
    .b       (bus.in_src2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = '0;
    unique case (bus.in_op)
      ALU_ADD:  alu_res = bus.in_src1 + bus.in_src2;
      ALU_SUB:  alu_res = bus.in_src1 - bus.in_src2;
      ALU_AND:  alu_res = bus.in_src1 & bus.in_src2;
      ALU_OR:   alu_res = bus.in_src1 | bus.in_src2;
      ALU_XOR:  alu_res = bus.in_src1 ^ bus.in_src2;
      ALU_SLL:  alu_res = bus.in_src1 << shamt;
      ALU_SRL:  alu_res = bus.in_src1 >> shamt;
      ALU_SRA:  alu_res = $signed(bus.in_src1) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_src1) < $signed(bus.in_src2))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.in_src1 < bus.in_src2)};
      ALU_EQ:   alu_res = {{(XLEN-1){1'b0}}, (bus.in_src1 == bus.in_src2)};
      ALU_NE:   alu_res = {{(XLEN-1){1'b0}}, (bus.in_src1 != bus.in_src2)};
      ALU_GE:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_src1) >= $signed(bus.in_src2))};
      ALU_GEU:  alu_res = {{(XLEN-1){1'b0}}, (bus.in_src1 >= bus.in_src2)};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    jaddr_c = bus.in_pc + bus.in_imm;
    if (bus.in_instr_type == INSTR_JALR) begin
      jaddr_c = (bus.in_rs1_data + bus.in_imm) & ~XLEN'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_next = is_mul ? ST_MUL_BUSY : ST_HOLD;
      end
      ST_MUL_BUSY: begin
        if (mul_done) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept)              state_next = is_mul ? ST_MUL_BUSY : ST_HOLD;
        else if (bus.out_ready)  state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // jmp is a one-cycle pulse raised only on the edge that enters HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      jmp_q   <= 1'b0;
      type_q  <= INSTR_NONE;
      mem_q   <= MEM_NONE;
      dest_q  <= '0;
      res_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      jaddr_q <= '0;
    end else begin
      state <= state_next;
      jmp_q <= 1'b0;
      if (!flush) begin
        if (accept) begin
          type_q  <= bus.in_instr_type;
          mem_q   <= bus.in_mem_type;
          dest_q  <= bus.in_dest;
          rs2_q   <= bus.in_rs2_data;
          imm_q   <= bus.in_imm;
          jaddr_q <= jaddr_c;
          if (!is_mul) begin
            res_q <= alu_res;
            jmp_q <= is_taken(bus.in_instr_type, alu_res[0]);
          end
        end else if ((state == ST_MUL_BUSY) && mul_done) begin
          res_q <= mul_product;
          jmp_q <= is_taken(type_q, mul_product[0]);
        end
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_instr_type = out_valid ? type_q : INSTR_NONE;
  assign bus.out_mem_type   = mem_q;
  assign bus.out_dest       = dest_q;
  assign bus.out_res        = res_q;
  assign bus.out_rs2_data   = rs2_q;
  assign bus.out_imm        = imm_q;
  assign bus.jmp            = jmp_q;
  assign bus.jmp_addr       = jaddr_q;
  assign bus.jmp_misaligned = jmp_q && (jaddr_q[1:0] != 2'b00);

endmodule
